// File: rtl/robo_executor_if.sv
// Command/status bundle between the wall-following controller and the motion executor.
// The controller drives the commands; the executor returns actuator drives and odometry.
interface robo_executor_if #(
    parameter int GRID_W = 4
);
    logic              avancar;
    logic              girar;
    logic              remover;
    logic              motor_esq;
    logic              motor_dir;
    logic              braco;
    logic              ocupado;
    logic              erro;
    logic [GRID_W-1:0] pos_x;
    logic [GRID_W-1:0] pos_y;
    logic [1:0]        direcao;
    logic [15:0]       movimentos;

    modport master (
        output avancar, girar, remover,
        input  motor_esq, motor_dir, braco, ocupado, erro,
        input  pos_x, pos_y, direcao, movimentos
    );

    modport slave (
        input  avancar, girar, remover,
        output motor_esq, motor_dir, braco, ocupado, erro,
        output pos_x, pos_y, direcao, movimentos
    );
endinterface

// File: rtl/robo_executor.sv
// Motion executor: turns one-hot avancar/girar/remover commands into timed actuator
// pulses and keeps grid position, heading and a saturating completed-command count.
module robo_executor #(
    parameter int T_AVANCO  = 8,
    parameter int T_GIRO    = 4,
    parameter int T_REMOCAO = 6,
    parameter int GRID_W    = 4,
    parameter int CNT_W     = 8
) (
    input logic           clock,
    input logic           reset,
    robo_executor_if.slave bus
);

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        AVANCANDO = 2'd1,
        GIRANDO   = 2'd2,
        REMOVENDO = 2'd3
    } estado_t;

    localparam logic [CNT_W-1:0] CARGA_AV  = CNT_W'(T_AVANCO - 1);
    localparam logic [CNT_W-1:0] CARGA_GI  = CNT_W'(T_GIRO - 1);
    localparam logic [CNT_W-1:0] CARGA_REM = CNT_W'(T_REMOCAO - 1);

    estado_t           estado;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        cmd;
    logic              motor_esq_q;
    logic              motor_dir_q;
    logic              braco_q;
    logic              ocupado_q;
    logic              erro_q;
    logic [GRID_W-1:0] pos_x_q;
    logic [GRID_W-1:0] pos_y_q;
    logic [1:0]        dir_q;
    logic [15:0]       mov_q;

    assign cmd = {bus.avancar, bus.girar, bus.remover};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado      <= OCIOSO;
            cnt         <= '0;
            motor_esq_q <= 1'b0;
            motor_dir_q <= 1'b0;
            braco_q     <= 1'b0;
            ocupado_q   <= 1'b0;
            erro_q      <= 1'b0;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            dir_q       <= '0;
            mov_q       <= '0;
        end else begin
            erro_q <= 1'b0;
            case (estado)
                OCIOSO: begin
                    case (cmd)
                        3'b000: ;
                        3'b100: begin
                            estado      <= AVANCANDO;
                            cnt         <= CARGA_AV;
                            motor_esq_q <= 1'b1;
                            motor_dir_q <= 1'b1;
                            ocupado_q   <= 1'b1;
                        end
                        3'b010: begin
                            estado      <= GIRANDO;
                            cnt         <= CARGA_GI;
                            motor_esq_q <= 1'b1;
                            ocupado_q   <= 1'b1;
                        end
                        3'b001: begin
                            estado    <= REMOVENDO;
                            cnt       <= CARGA_REM;
                            braco_q   <= 1'b1;
                            ocupado_q <= 1'b1;
                        end
                        default: erro_q <= 1'b1;
                    endcase
                end
                AVANCANDO, GIRANDO, REMOVENDO: begin
                    if (cnt == '0) begin
                        // Odometry commits on the same edge that drops the actuators.
                        estado      <= OCIOSO;
                        motor_esq_q <= 1'b0;
                        motor_dir_q <= 1'b0;
                        braco_q     <= 1'b0;
                        ocupado_q   <= 1'b0;
                        if (mov_q != '1)
                            mov_q <= mov_q + 16'd1;
                        if (estado == AVANCANDO) begin
                            case (dir_q)
                                2'd0: pos_y_q <= pos_y_q + 1'b1;
                                2'd1: pos_x_q <= pos_x_q + 1'b1;
                                2'd2: pos_y_q <= pos_y_q - 1'b1;
                                default: pos_x_q <= pos_x_q - 1'b1;
                            endcase
                        end else if (estado == GIRANDO) begin
                            dir_q <= dir_q + 2'd1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    estado      <= OCIOSO;
                    cnt         <= '0;
                    motor_esq_q <= 1'b0;
                    motor_dir_q <= 1'b0;
                    braco_q     <= 1'b0;
                    ocupado_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.motor_esq  = motor_esq_q;
    assign bus.motor_dir  = motor_dir_q;
    assign bus.braco      = braco_q;
    assign bus.ocupado    = ocupado_q;
    assign bus.erro       = erro_q;
    assign bus.pos_x      = pos_x_q;
    assign bus.pos_y      = pos_y_q;
    assign bus.direcao    = dir_q;
    assign bus.movimentos = mov_q;

endmodule

// File: tb/tb_robo_executor.sv
// Directed bench for robo_executor with default timing (8/4/6 cycles, 4-bit grid).
module tb_robo_executor;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    robo_executor_if #(.GRID_W(4)) bus ();

    robo_executor #(
        .T_AVANCO (8),
        .T_GIRO   (4),
        .T_REMOCAO(6),
        .GRID_W   (4),
        .CNT_W    (8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulse one command for a single sampling edge, then wait out t cycles so the
    // executor is idle again on return (we sit at a falling edge).
    task automatic do_cmd(input logic a, input logic g, input logic r, input int t);
        @(negedge clock);
        bus.avancar = a; bus.girar = g; bus.remover = r;
        @(negedge clock);
        bus.avancar = 1'b0; bus.girar = 1'b0; bus.remover = 1'b0;
        repeat (t) @(negedge clock);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.avancar = 1'b0; bus.girar = 1'b0; bus.remover = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({bus.motor_esq, bus.motor_dir, bus.braco, bus.ocupado, bus.erro} !== 5'b0) begin
            errors++;
            $display("FAIL reset_drives: got %b want 00000",
                     {bus.motor_esq, bus.motor_dir, bus.braco, bus.ocupado, bus.erro});
        end
        checks++;
        if ({bus.pos_x, bus.pos_y, bus.direcao, bus.movimentos} !== 26'h0) begin
            errors++;
            $display("FAIL reset_odometry: x=%0d y=%0d dir=%0d mov=%0d want all 0",
                     bus.pos_x, bus.pos_y, bus.direcao, bus.movimentos);
        end
    endtask

    task automatic test_avancar;
        int bad = 0;
        @(negedge clock);
        bus.avancar = 1'b1;
        @(negedge clock);
        bus.avancar = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ({bus.motor_esq, bus.motor_dir, bus.braco, bus.ocupado} !== 4'b1101) bad++;
            @(negedge clock);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL avancar_pulse: %0d of 8 cycles wrong, want motors+ocupado high", bad);
        end
        checks++;
        if ({bus.motor_esq, bus.motor_dir, bus.ocupado} !== 3'b000) begin
            errors++;
            $display("FAIL avancar_end: got %b want 000", {bus.motor_esq, bus.motor_dir, bus.ocupado});
        end
        checks++;
        if (bus.pos_x !== 4'd0 || bus.pos_y !== 4'd1 || bus.direcao !== 2'd0 || bus.movimentos !== 16'd1) begin
            errors++;
            $display("FAIL avancar_odometry: x=%0d y=%0d dir=%0d mov=%0d want 0 1 0 1",
                     bus.pos_x, bus.pos_y, bus.direcao, bus.movimentos);
        end
    endtask

    task automatic test_girar;
        logic [1:0] want_dir [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int n = 0; n < 4; n++) begin
            int bad = 0;
            @(negedge clock);
            bus.girar = 1'b1;
            @(negedge clock);
            bus.girar = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if ({bus.motor_esq, bus.motor_dir, bus.braco, bus.ocupado} !== 4'b1001) bad++;
                @(negedge clock);
            end
            checks++;
            if (bad != 0 || bus.ocupado !== 1'b0 || bus.motor_esq !== 1'b0) begin
                errors++;
                $display("FAIL girar_pulse[%0d]: %0d bad cycles, esq=%b ocupado=%b after", n, bad,
                         bus.motor_esq, bus.ocupado);
            end
            checks++;
            if (bus.direcao !== want_dir[n]) begin
                errors++;
                $display("FAIL girar_dir[%0d]: got %0d want %0d", n, bus.direcao, want_dir[n]);
            end
        end
        checks++;
        if (bus.movimentos !== 16'd5 || bus.pos_y !== 4'd1) begin
            errors++;
            $display("FAIL girar_count: mov=%0d y=%0d want 5 1", bus.movimentos, bus.pos_y);
        end
    endtask

    // girar held high: the second action starts only after one idle sampling cycle.
    task automatic test_back_to_back;
        logic [9:0] got;
        @(negedge clock);
        bus.girar = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            got[9 - i] = bus.ocupado;
            if (i == 5) bus.girar = 1'b0;
        end
        checks++;
        if (got !== 10'b1111011110) begin
            errors++;
            $display("FAIL back_to_back_ocupado: got %b want 1111011110", got);
        end
        checks++;
        if (bus.direcao !== 2'd2 || bus.movimentos !== 16'd7) begin
            errors++;
            $display("FAIL back_to_back_odometry: dir=%0d mov=%0d want 2 7", bus.direcao, bus.movimentos);
        end
    endtask

    task automatic test_wrap;
        do_cmd(1'b0, 1'b1, 1'b0, 4);             // S -> W
        do_cmd(1'b1, 1'b0, 1'b0, 8);             // x 0 -> 15
        checks++;
        if (bus.pos_x !== 4'd15 || bus.pos_y !== 4'd1 || bus.direcao !== 2'd3 || bus.movimentos !== 16'd9) begin
            errors++;
            $display("FAIL wrap_x: x=%0d y=%0d dir=%0d mov=%0d want 15 1 3 9",
                     bus.pos_x, bus.pos_y, bus.direcao, bus.movimentos);
        end
        repeat (3) do_cmd(1'b0, 1'b1, 1'b0, 4);  // W -> S
        repeat (2) do_cmd(1'b1, 1'b0, 1'b0, 8);  // y 1 -> 0 -> 15
        checks++;
        if (bus.pos_y !== 4'd15 || bus.direcao !== 2'd2 || bus.movimentos !== 16'd14) begin
            errors++;
            $display("FAIL wrap_y_south: y=%0d dir=%0d mov=%0d want 15 2 14",
                     bus.pos_y, bus.direcao, bus.movimentos);
        end
        repeat (2) do_cmd(1'b0, 1'b1, 1'b0, 4);  // S -> N
        do_cmd(1'b1, 1'b0, 1'b0, 8);             // y 15 -> 0
        checks++;
        if (bus.pos_x !== 4'd15 || bus.pos_y !== 4'd0 || bus.direcao !== 2'd0 || bus.movimentos !== 16'd17) begin
            errors++;
            $display("FAIL wrap_y_north: x=%0d y=%0d dir=%0d mov=%0d want 15 0 0 17",
                     bus.pos_x, bus.pos_y, bus.direcao, bus.movimentos);
        end
    endtask

    task automatic test_erro;
        @(negedge clock);
        bus.avancar = 1'b1; bus.girar = 1'b1;
        @(negedge clock);
        bus.avancar = 1'b0; bus.girar = 1'b0;
        checks++;
        if ({bus.erro, bus.ocupado, bus.motor_esq, bus.motor_dir} !== 4'b1000) begin
            errors++;
            $display("FAIL erro_pulse: erro/ocupado/esq/dir=%b want 1000",
                     {bus.erro, bus.ocupado, bus.motor_esq, bus.motor_dir});
        end
        @(negedge clock);
        checks++;
        if (bus.erro !== 1'b0 || bus.ocupado !== 1'b0 || bus.movimentos !== 16'd17 || bus.pos_y !== 4'd0) begin
            errors++;
            $display("FAIL erro_after: erro=%b ocupado=%b mov=%0d y=%0d want 0 0 17 0",
                     bus.erro, bus.ocupado, bus.movimentos, bus.pos_y);
        end
    endtask

    task automatic test_ignore_during_action;
        int bad = 0;
        @(negedge clock);
        bus.avancar = 1'b1;
        @(negedge clock);
        bus.avancar = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) bus.remover = 1'b1;
            if (i == 5) bus.remover = 1'b0;
            if (bus.braco !== 1'b0 || bus.ocupado !== 1'b1) bad++;
            @(negedge clock);
        end
        repeat (8) begin
            if (bus.braco !== 1'b0 || bus.ocupado !== 1'b0) bad++;
            @(negedge clock);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ignore_remover: %0d bad cycles, braco must stay 0", bad);
        end
        checks++;
        if (bus.pos_y !== 4'd1 || bus.movimentos !== 16'd18) begin
            errors++;
            $display("FAIL ignore_odometry: y=%0d mov=%0d want 1 18", bus.pos_y, bus.movimentos);
        end
    endtask

    task automatic test_reset_abort;
        @(negedge clock);
        bus.remover = 1'b1;
        @(negedge clock);
        bus.remover = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (bus.braco !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: braco=%b want 1", bus.braco);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.braco, bus.ocupado} !== 2'b00 || bus.movimentos !== 16'd0 || bus.pos_x !== 4'd0) begin
            errors++;
            $display("FAIL abort_async: braco=%b ocupado=%b mov=%0d x=%0d want 0 0 0 0",
                     bus.braco, bus.ocupado, bus.movimentos, bus.pos_x);
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (8) @(negedge clock);
        checks++;
        if ({bus.braco, bus.ocupado} !== 2'b00 || bus.movimentos !== 16'd0) begin
            errors++;
            $display("FAIL abort_after: braco=%b ocupado=%b mov=%0d want 0 0 0",
                     bus.braco, bus.ocupado, bus.movimentos);
        end
    endtask

    task automatic test_saturation;
        int bad = 0;
        @(negedge clock);
        dut.mov_q = 16'hFFFE;
        @(negedge clock);
        bus.remover = 1'b1;
        @(negedge clock);
        bus.remover = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if ({bus.motor_esq, bus.motor_dir, bus.braco, bus.ocupado} !== 4'b0011) bad++;
            @(negedge clock);
        end
        checks++;
        if (bad != 0 || bus.braco !== 1'b0) begin
            errors++;
            $display("FAIL remover_pulse: %0d bad cycles, braco after=%b", bad, bus.braco);
        end
        checks++;
        if (bus.movimentos !== 16'hFFFF || bus.pos_x !== 4'd0 || bus.pos_y !== 4'd0 || bus.direcao !== 2'd0) begin
            errors++;
            $display("FAIL sat_first: mov=%h x=%0d y=%0d dir=%0d want ffff 0 0 0",
                     bus.movimentos, bus.pos_x, bus.pos_y, bus.direcao);
        end
        do_cmd(1'b0, 1'b0, 1'b1, 6);
        checks++;
        if (bus.movimentos !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold: mov=%h want ffff", bus.movimentos);
        end
    endtask

    initial begin
        test_reset;
        test_avancar;
        test_girar;
        test_back_to_back;
        test_wrap;
        test_erro;
        test_ignore_during_action;
        test_reset_abort;
        test_saturation;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
